// File: rtl/axi_mem_slave_pkg.sv
// Shared AXI3 constants and FSM state types for the memory responder.
// No logic: constants and types only, so there is no latency or backpressure here.
package axi_mem_slave_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic int unsigned bytes_log2(input int unsigned data_bits);
    return $clog2(data_bits / 8);
  endfunction

endpackage

// File: rtl/axi_mem_slave_ram_dp_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read port with enable.
// One-cycle read latency, read-first on a same-word collision; never stalls.
module ram_dp_be #(
  parameter int DataBits = 64,
  parameter int AddrBits = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AddrBits-1:0]   waddr,
  input  logic [DataBits/8-1:0] be,
  input  logic [DataBits-1:0]   wdata,
  input  logic                  re,
  input  logic [AddrBits-1:0]   raddr,
  output logic [DataBits-1:0]   rdata
);

  logic [DataBits-1:0] mem [2**AddrBits];

  // Non-blocking updates give read-first behaviour when waddr == raddr.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DataBits / 8; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 INCR-only memory responder with independent write (AW/W/B) and read (AR/R) FSMs.
// First R beat 2 cycles after AR; one beat per cycle after that; all channels hold under backpressure.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int DataBits    = 64,
  parameter int AxiAddrBits = 32,
  parameter int MemAddrBits = 12,
  parameter int IdBits      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   slv_awvalid,
  output logic                   slv_awready,
  input  logic [IdBits-1:0]      slv_awid,
  input  logic [AxiAddrBits-1:0] slv_awaddr,
  input  logic [3:0]             slv_awlen,
  input  logic [2:0]             slv_awsize,
  input  logic [1:0]             slv_awlock,
  input  logic [1:0]             slv_awburst,
  input  logic                   slv_wvalid,
  output logic                   slv_wready,
  input  logic [IdBits-1:0]      slv_wid,
  input  logic [DataBits/8-1:0]  slv_wstrb,
  input  logic                   slv_wlast,
  input  logic [DataBits-1:0]    slv_wdata,
  output logic                   slv_bvalid,
  input  logic                   slv_bready,
  output logic [IdBits-1:0]      slv_bid,
  output logic [1:0]             slv_bresp,
  input  logic                   slv_arvalid,
  output logic                   slv_arready,
  input  logic [IdBits-1:0]      slv_arid,
  input  logic [AxiAddrBits-1:0] slv_araddr,
  input  logic [3:0]             slv_arlen,
  input  logic [2:0]             slv_arsize,
  input  logic [1:0]             slv_arlock,
  input  logic [1:0]             slv_arburst,
  output logic                   slv_rvalid,
  input  logic                   slv_rready,
  output logic [IdBits-1:0]      slv_rid,
  output logic [DataBits-1:0]    slv_rdata,
  output logic [1:0]             slv_rresp,
  output logic                   slv_rlast
);

  localparam int SizeLog2 = bytes_log2(DataBits);
  localparam int IdxBits  = MemAddrBits - SizeLog2;
  localparam logic [2:0]         SizeCode = 3'(SizeLog2);
  localparam logic [IdxBits-1:0] IdxOne   = 1;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [IdBits-1:0]  w_id, r_id;
  logic [IdxBits-1:0] w_idx, r_idx;
  logic [3:0]         w_len, w_cnt, r_len, r_cnt;
  logic               w_err, r_err;
  logic               ram_we, ram_re;
  logic               aw_fire, w_fire, ar_fire, r_fire;
  logic               unused_in;

  assign unused_in = ^{slv_awlock, slv_arlock, slv_wid, slv_awaddr, slv_araddr};

  assign aw_fire = slv_awvalid & slv_awready;
  assign w_fire  = slv_wvalid & slv_wready;
  assign ar_fire = slv_arvalid & slv_arready;
  assign r_fire  = slv_rvalid & slv_rready;

  // Outputs are forced idle while rst is high so no handshake can complete during reset.
  always_comb begin
    w_next      = w_state;
    slv_awready = 1'b0;
    slv_wready  = 1'b0;
    slv_bvalid  = 1'b0;
    slv_bresp   = RESP_OKAY;
    ram_we      = 1'b0;
    if (!rst) begin
      unique case (w_state)
        W_IDLE: begin
          slv_awready = 1'b1;
          if (slv_awvalid) w_next = W_DATA;
        end
        W_DATA: begin
          slv_wready = 1'b1;
          if (slv_wvalid) begin
            ram_we = !w_err;
            if (w_cnt == w_len) w_next = W_RESP;
          end
        end
        W_RESP: begin
          slv_bvalid = 1'b1;
          slv_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
          if (slv_bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  assign slv_bid = w_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        w_id  <= slv_awid;
        w_idx <= slv_awaddr[MemAddrBits-1:SizeLog2];
        w_len <= slv_awlen;
        w_cnt <= '0;
        w_err <= (slv_awburst != BURST_INCR) || (slv_awsize != SizeCode);
      end
      if (w_fire) begin
        w_idx <= w_idx + IdxOne;
        w_cnt <= w_cnt + 4'd1;
        // wlast must coincide with the final beat; an early one still consumes the full burst.
        if (slv_wlast != (w_cnt == w_len)) w_err <= 1'b1;
      end
    end
  end

  always_comb begin
    r_next      = r_state;
    slv_arready = 1'b0;
    slv_rvalid  = 1'b0;
    slv_rlast   = 1'b0;
    slv_rresp   = RESP_OKAY;
    ram_re      = 1'b0;
    if (!rst) begin
      unique case (r_state)
        R_IDLE: begin
          slv_arready = 1'b1;
          if (slv_arvalid) r_next = R_FETCH;
        end
        R_FETCH: begin
          ram_re = 1'b1;
          r_next = R_DATA;
        end
        R_DATA: begin
          slv_rvalid = 1'b1;
          slv_rlast  = (r_cnt == r_len);
          slv_rresp  = r_err ? RESP_SLVERR : RESP_OKAY;
          // Prefetch the next word on the handshake so the read register feeds rdata directly.
          if (slv_rready) begin
            if (slv_rlast) r_next = R_IDLE;
            else           ram_re = 1'b1;
          end
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  assign slv_rid = r_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        r_id  <= slv_arid;
        r_idx <= slv_araddr[MemAddrBits-1:SizeLog2];
        r_len <= slv_arlen;
        r_cnt <= '0;
        r_err <= (slv_arburst != BURST_INCR) || (slv_arsize != SizeCode);
      end
      if (ram_re) r_idx <= r_idx + IdxOne;
      if (r_fire) r_cnt <= r_cnt + 4'd1;
    end
  end

  ram_dp_be #(
    .DataBits (DataBits),
    .AddrBits (IdxBits)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_idx),
    .be    (slv_wstrb),
    .wdata (slv_wdata),
    .re    (ram_re),
    .raddr (r_idx),
    .rdata (slv_rdata)
  );

endmodule
